// File: rtl/cg_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cg_pkg
//  Description : Shared types and constants for the conjugate-gradient
//                iteration sequencer: FSM state encoding, scalar width,
//                default convergence tolerance and a wait-state helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cg_pkg;

    localparam int          c_ELEMENT_WIDTH = 32;
    // IEEE-754 single-precision bit pattern of the default tolerance
    localparam logic [31:0] c_TOLERANCE     = 32'h283424DC;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RSOLD  = 4'd1,
        S_AP     = 4'd2,
        S_UPD_XR = 4'd3,
        S_RSNEW  = 4'd4,
        S_DIV2   = 4'd5,
        S_UPD_P  = 4'd6,
        S_DONE   = 4'd7,
        S_ERROR  = 4'd8
    } cg_state_t;

    // States that wait on a datapath finish flag (watchdog-guarded, busy)
    function automatic logic is_wait_state(input cg_state_t s);
        return (s == S_RSOLD) || (s == S_AP) || (s == S_UPD_XR) ||
               (s == S_RSNEW) || (s == S_DIV2) || (s == S_UPD_P);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cg_iteration_sequencer_stage_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : stage_watchdog
//  Description : Per-state cycle counter. Cleared on every state entry,
//                counts while enabled, and flags a hit on the TIMEOUT-th
//                consecutive enabled cycle.
//  Ports       : clk    - system clock
//                reset  - asynchronous, active-low reset
//                clear  - synchronous counter clear (state change)
//                enable - count this cycle (wait state active)
//                hit    - counter has reached TIMEOUT enabled cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int c_CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [c_CW-1:0] r_count;

    // The count holds the number of completed cycles in the current state,
    // so the hit fires during the TIMEOUT-th cycle and the FSM leaves at the
    // edge closing that cycle.
    assign hit = enable && (r_count == c_CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !hit) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cg_iteration_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cg_iteration_sequencer
//  Description : Conjugate-gradient control sequencer. Steps the ALU stages
//                in CG order (rs_old, Ap, x/r update, rs_new, div2, p update),
//                holds the rs_old/rs_new scalars, applies the convergence
//                tolerance and iteration limit, and guards every wait with
//                a watchdog.
//  Ports       : clk, reset (async, active-low)
//                start (level), abort (sync)
//                *_finish          - stage done flags
//                vxv1/vxv3_result  - r.r dot-product results
//                *_run             - level run enables (datapath reset = !run)
//                div2_start        - single-cycle pulse on DIV2 entry
//                rs_old, rs_new    - latched scalars (div2 operands)
//                iter_count        - completed iterations
//                busy, done, converged, error - status
//  Revision    : 1.0 - initial release
// ============================================================================
module cg_iteration_sequencer
    import cg_pkg::*;
#(
    parameter int                       ELEMENT_WIDTH = c_ELEMENT_WIDTH,
    parameter logic [ELEMENT_WIDTH-1:0] TOLERANCE     = c_TOLERANCE,
    parameter int                       MAX_ITER      = 16,
    parameter int                       ITER_WIDTH    = 16,
    parameter int                       TIMEOUT       = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     vxv1_finish,
    input  logic                     vxv3_finish,
    input  logic                     div1_finish,
    input  logic                     div2_finish,
    input  logic                     mul_add1_finish,
    input  logic                     mul_add2_finish,
    input  logic                     mul_add3_finish,
    input  logic [ELEMENT_WIDTH-1:0] vxv1_result,
    input  logic [ELEMENT_WIDTH-1:0] vxv3_result,
    output logic                     vxv1_run,
    output logic                     mxv_run,
    output logic                     upd_xr_run,
    output logic                     vxv3_run,
    output logic                     upd_p_run,
    output logic                     div2_start,
    output logic [ELEMENT_WIDTH-1:0] rs_old,
    output logic [ELEMENT_WIDTH-1:0] rs_new,
    output logic [ITER_WIDTH-1:0]    iter_count,
    output logic                     busy,
    output logic                     done,
    output logic                     converged,
    output logic                     error
);

    cg_state_t r_state;
    cg_state_t w_state_nxt;

    logic r_ma1_seen, r_ma2_seen;
    logic w_ma1_any,  w_ma2_any;
    logic w_wd_hit, w_wd_clear, w_wd_enable;

    logic w_ld_rs_old_vxv, w_ld_rs_old_new, w_ld_rs_new;
    logic w_iter_clr, w_iter_step, w_status_clr, w_set_conv, w_flags_clr;

    logic [ITER_WIDTH-1:0] w_iter_inc;

    logic                     r_vxv1_run, r_mxv_run, r_upd_xr_run, r_vxv3_run, r_upd_p_run;
    logic                     r_div2_start, r_busy, r_done, r_converged, r_error;
    logic [ELEMENT_WIDTH-1:0] r_rs_old, r_rs_new;
    logic [ITER_WIDTH-1:0]    r_iter;

    assign w_iter_inc = r_iter + 1'b1;

    // Sticky flag OR the live flag, so simultaneous or out-of-order
    // arrivals both release UPD_XR on the edge of the later one.
    assign w_ma1_any = r_ma1_seen | mul_add1_finish;
    assign w_ma2_any = r_ma2_seen | mul_add2_finish;

    assign w_wd_clear  = (w_state_nxt != r_state);
    assign w_wd_enable = is_wait_state(r_state);

    stage_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_wd_clear),
        .enable (w_wd_enable),
        .hit    (w_wd_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus datapath load strobes. A finish flag wins over a
    // watchdog hit in the same cycle; abort wins over everything.
    always_comb begin
        w_state_nxt     = r_state;
        w_ld_rs_old_vxv = 1'b0;
        w_ld_rs_old_new = 1'b0;
        w_ld_rs_new     = 1'b0;
        w_iter_clr      = 1'b0;
        w_iter_step     = 1'b0;
        w_status_clr    = 1'b0;
        w_set_conv      = 1'b0;
        w_flags_clr     = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_flags_clr = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt  = S_RSOLD;
                        w_iter_clr   = 1'b1;
                        w_status_clr = 1'b1;
                    end
                end
                S_RSOLD: begin
                    if (vxv1_finish) begin
                        w_ld_rs_old_vxv = 1'b1;
                        w_state_nxt     = S_AP;
                    end else if (w_wd_hit) begin
                        w_state_nxt = S_ERROR;
                    end
                end
                S_AP: begin
                    if (div1_finish)   w_state_nxt = S_UPD_XR;
                    else if (w_wd_hit) w_state_nxt = S_ERROR;
                end
                S_UPD_XR: begin
                    if (w_ma1_any && w_ma2_any) begin
                        w_state_nxt = S_RSNEW;
                        w_flags_clr = 1'b1;
                    end else if (w_wd_hit) begin
                        w_state_nxt = S_ERROR;
                        w_flags_clr = 1'b1;
                    end
                end
                S_RSNEW: begin
                    if (vxv3_finish) begin
                        w_ld_rs_new = 1'b1;
                        if (vxv3_result <= TOLERANCE) begin
                            w_state_nxt = S_DONE;
                            w_set_conv  = 1'b1;
                        end else if (w_iter_inc == ITER_WIDTH'(MAX_ITER)) begin
                            w_state_nxt = S_DONE;
                            w_iter_step = 1'b1;
                        end else begin
                            w_state_nxt = S_DIV2;
                        end
                    end else if (w_wd_hit) begin
                        w_state_nxt = S_ERROR;
                    end
                end
                S_DIV2: begin
                    if (div2_finish)   w_state_nxt = S_UPD_P;
                    else if (w_wd_hit) w_state_nxt = S_ERROR;
                end
                S_UPD_P: begin
                    if (mul_add3_finish) begin
                        w_ld_rs_old_new = 1'b1;
                        w_iter_step     = 1'b1;
                        w_state_nxt     = S_AP;
                    end else if (w_wd_hit) begin
                        w_state_nxt = S_ERROR;
                    end
                end
                S_DONE: begin
                    if (!start) w_state_nxt = S_IDLE;
                end
                S_ERROR: begin
                    if (!start) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so each run is high in the
    // first cycle of its state, with no idle gap between stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vxv1_run   <= 1'b0;
            r_mxv_run    <= 1'b0;
            r_upd_xr_run <= 1'b0;
            r_vxv3_run   <= 1'b0;
            r_upd_p_run  <= 1'b0;
            r_div2_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_converged  <= 1'b0;
            r_error      <= 1'b0;
            r_rs_old     <= '0;
            r_rs_new     <= '0;
            r_iter       <= '0;
            r_ma1_seen   <= 1'b0;
            r_ma2_seen   <= 1'b0;
        end else begin
            r_vxv1_run   <= (w_state_nxt == S_RSOLD);
            r_mxv_run    <= (w_state_nxt == S_AP);
            r_upd_xr_run <= (w_state_nxt == S_UPD_XR);
            r_vxv3_run   <= (w_state_nxt == S_RSNEW);
            r_upd_p_run  <= (w_state_nxt == S_UPD_P);
            r_div2_start <= (w_state_nxt == S_DIV2) && (r_state != S_DIV2);
            r_busy       <= is_wait_state(w_state_nxt);

            // Status bits are sticky through IDLE until the next start
            if (w_status_clr) begin
                r_done      <= 1'b0;
                r_converged <= 1'b0;
                r_error     <= 1'b0;
            end else begin
                if (w_state_nxt == S_DONE)  r_done      <= 1'b1;
                if (w_set_conv)             r_converged <= 1'b1;
                if (w_state_nxt == S_ERROR) r_error     <= 1'b1;
            end

            if (w_ld_rs_old_vxv)      r_rs_old <= vxv1_result;
            else if (w_ld_rs_old_new) r_rs_old <= r_rs_new;
            if (w_ld_rs_new)          r_rs_new <= vxv3_result;

            if (w_iter_clr)       r_iter <= '0;
            else if (w_iter_step) r_iter <= w_iter_inc;

            if (w_flags_clr) begin
                r_ma1_seen <= 1'b0;
                r_ma2_seen <= 1'b0;
            end else if (r_state == S_UPD_XR) begin
                if (mul_add1_finish) r_ma1_seen <= 1'b1;
                if (mul_add2_finish) r_ma2_seen <= 1'b1;
            end
        end
    end

    assign vxv1_run   = r_vxv1_run;
    assign mxv_run    = r_mxv_run;
    assign upd_xr_run = r_upd_xr_run;
    assign vxv3_run   = r_vxv3_run;
    assign upd_p_run  = r_upd_p_run;
    assign div2_start = r_div2_start;
    assign rs_old     = r_rs_old;
    assign rs_new     = r_rs_new;
    assign iter_count = r_iter;
    assign busy       = r_busy;
    assign done       = r_done;
    assign converged  = r_converged;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_cg_iteration_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cg_iteration_sequencer
//  Description : Directed self-checking bench for cg_iteration_sequencer.
//                Inputs change on the falling edge, outputs are sampled on
//                the falling edge, half a cycle away from the active edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cg_iteration_sequencer;

    localparam int c_P_VXV1 = 0;
    localparam int c_P_DIV1 = 1;
    localparam int c_P_MA12 = 2;
    localparam int c_P_VXV3 = 3;
    localparam int c_P_DIV2 = 4;
    localparam int c_P_MA3  = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic        vxv1_finish = 1'b0, vxv3_finish = 1'b0;
    logic        div1_finish = 1'b0, div2_finish = 1'b0;
    logic        mul_add1_finish = 1'b0, mul_add2_finish = 1'b0, mul_add3_finish = 1'b0;
    logic [31:0] vxv1_result = '0, vxv3_result = '0;
    logic        vxv1_run, mxv_run, upd_xr_run, vxv3_run, upd_p_run, div2_start;
    logic [31:0] rs_old, rs_new;
    logic [15:0] iter_count;
    logic        busy, done, converged, error;
    logic [4:0]  runs;

    int total = 0;
    int bad   = 0;
    int div2_cnt  = 0;
    int updp_seen = 0;

    assign runs = {vxv1_run, mxv_run, upd_xr_run, vxv3_run, upd_p_run};

    always #5 clk = ~clk;

    cg_iteration_sequencer #(
        .ELEMENT_WIDTH (32),
        .TOLERANCE     (32'h283424DC),
        .MAX_ITER      (4),
        .ITER_WIDTH    (16),
        .TIMEOUT       (64)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .vxv1_finish     (vxv1_finish),
        .vxv3_finish     (vxv3_finish),
        .div1_finish     (div1_finish),
        .div2_finish     (div2_finish),
        .mul_add1_finish (mul_add1_finish),
        .mul_add2_finish (mul_add2_finish),
        .mul_add3_finish (mul_add3_finish),
        .vxv1_result     (vxv1_result),
        .vxv3_result     (vxv3_result),
        .vxv1_run        (vxv1_run),
        .mxv_run         (mxv_run),
        .upd_xr_run      (upd_xr_run),
        .vxv3_run        (vxv3_run),
        .upd_p_run       (upd_p_run),
        .div2_start      (div2_start),
        .rs_old          (rs_old),
        .rs_new          (rs_new),
        .iter_count      (iter_count),
        .busy            (busy),
        .done            (done),
        .converged       (converged),
        .error           (error)
    );

    // Event monitors; tests compare deltas of these running totals
    always @(posedge clk) begin
        if (div2_start === 1'b1) div2_cnt++;
        if (upd_p_run  === 1'b1) updp_seen++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded, want finish earlier");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Hold one finish (or both mul_add1/2) high for one cycle
    task automatic pulse(input int id, input logic [31:0] val);
        case (id)
            c_P_VXV1: begin vxv1_finish = 1'b1; vxv1_result = val; end
            c_P_DIV1: div1_finish = 1'b1;
            c_P_MA12: begin mul_add1_finish = 1'b1; mul_add2_finish = 1'b1; end
            c_P_VXV3: begin vxv3_finish = 1'b1; vxv3_result = val; end
            c_P_DIV2: div2_finish = 1'b1;
            default:  mul_add3_finish = 1'b1;
        endcase
        tick();
        vxv1_finish = 1'b0; div1_finish = 1'b0; mul_add1_finish = 1'b0;
        mul_add2_finish = 1'b0; vxv3_finish = 1'b0; div2_finish = 1'b0;
        mul_add3_finish = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        total++; if ({runs, div2_start, busy, done, converged, error} !== 10'b0) begin bad++; $display("FAIL reset_flags: got %b want 0", {runs, div2_start, busy, done, converged, error}); end
        total++; if ({rs_old, rs_new, iter_count} !== 80'b0) begin bad++; $display("FAIL reset_regs: rs_old=%h rs_new=%h iter=%0d want 0", rs_old, rs_new, iter_count); end
        reset = 1'b1;
        tick();
        total++; if (runs !== 5'b0) begin bad++; $display("FAIL idle_runs: got %b want 00000", runs); end
    endtask

    task automatic test_converge();
        int d0, u0;
        d0 = div2_cnt; u0 = updp_seen;
        start = 1'b1;
        tick();
        total++; if (runs !== 5'b10000 || busy !== 1'b1) begin bad++; $display("FAIL start_latency: runs=%b busy=%b want 10000/1", runs, busy); end
        pulse(c_P_VXV1, 32'h3F000000);
        total++; if (runs !== 5'b01000 || rs_old !== 32'h3F000000) begin bad++; $display("FAIL rsold_latch: runs=%b rs_old=%h want 01000/3f000000", runs, rs_old); end
        pulse(c_P_DIV1, 32'h0);
        total++; if (runs !== 5'b00100) begin bad++; $display("FAIL ap_to_updxr: runs=%b want 00100", runs); end
        pulse(c_P_MA12, 32'h0);
        total++; if (runs !== 5'b00010) begin bad++; $display("FAIL updxr_to_rsnew: runs=%b want 00010", runs); end
        pulse(c_P_VXV3, 32'h28000000);
        total++; if ({done, converged, busy} !== 3'b110 || iter_count !== 16'd0 || runs !== 5'b0) begin bad++; $display("FAIL converge_status: done=%b conv=%b busy=%b iter=%0d runs=%b want 1/1/0/0/00000", done, converged, busy, iter_count, runs); end
        total++; if (rs_new !== 32'h28000000) begin bad++; $display("FAIL converge_rsnew: got %h want 28000000", rs_new); end
        total++; if (div2_cnt - d0 != 0 || updp_seen - u0 != 0) begin bad++; $display("FAIL converge_no_div2: div2=%0d updp=%0d want 0/0", div2_cnt - d0, updp_seen - u0); end
        start = 1'b0;
        tick();
        tick();
        total++; if (done !== 1'b1 || busy !== 1'b0 || runs !== 5'b0) begin bad++; $display("FAIL done_sticky_idle: done=%b busy=%b runs=%b want 1/0/00000", done, busy, runs); end
    endtask

    task automatic test_iter_limit();
        int d0;
        d0 = div2_cnt;
        start = 1'b1;
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_clear_on_start: got %b want 0", done); end
        pulse(c_P_VXV1, 32'h40000000);
        for (int k = 0; k < 4; k++) begin
            pulse(c_P_DIV1, 32'h0);
            pulse(c_P_MA12, 32'h0);
            pulse(c_P_VXV3, 32'h3F800000);
            if (k < 3) begin
                total++; if (div2_start !== 1'b1 || runs !== 5'b0) begin bad++; $display("FAIL div2_entry k=%0d: div2_start=%b runs=%b want 1/00000", k, div2_start, runs); end
                pulse(c_P_DIV2, 32'h0);
                total++; if (div2_start !== 1'b0 || runs !== 5'b00001) begin bad++; $display("FAIL updp_entry k=%0d: div2_start=%b runs=%b want 0/00001", k, div2_start, runs); end
                pulse(c_P_MA3, 32'h0);
                total++; if (rs_old !== 32'h3F800000 || iter_count !== 16'(k + 1) || runs !== 5'b01000) begin bad++; $display("FAIL updp_exit k=%0d: rs_old=%h iter=%0d runs=%b want 3f800000/%0d/01000", k, rs_old, iter_count, runs, k + 1); end
            end else begin
                total++; if ({done, converged} !== 2'b10 || iter_count !== 16'd4) begin bad++; $display("FAIL iter_limit: done=%b conv=%b iter=%0d want 1/0/4", done, converged, iter_count); end
                total++; if (div2_cnt - d0 != 3) begin bad++; $display("FAIL div2_pulses: got %0d want 3", div2_cnt - d0); end
            end
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_updxr_order();
        start = 1'b1;
        tick();
        pulse(c_P_VXV1, 32'h3F000000);
        // mul_add1 outside UPD_XR must be ignored
        mul_add1_finish = 1'b1;
        tick();
        mul_add1_finish = 1'b0;
        pulse(c_P_DIV1, 32'h0);
        mul_add2_finish = 1'b1;
        tick();
        mul_add2_finish = 1'b0;
        total++; if (runs !== 5'b00100) begin bad++; $display("FAIL ma2_only_stays: runs=%b want 00100", runs); end
        repeat (4) tick();
        total++; if (runs !== 5'b00100) begin bad++; $display("FAIL ma2_wait_stays: runs=%b want 00100", runs); end
        mul_add1_finish = 1'b1;
        tick();
        mul_add1_finish = 1'b0;
        total++; if (runs !== 5'b00010) begin bad++; $display("FAIL ma1_late_exit: runs=%b want 00010", runs); end
        pulse(c_P_VXV3, 32'h28000000);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        pulse(c_P_VXV1, 32'h3F000000);
        pulse(c_P_DIV1, 32'h0);
        total++; if (runs !== 5'b00100) begin bad++; $display("FAIL updxr_second_entry: runs=%b want 00100", runs); end
        pulse(c_P_MA12, 32'h0);
        total++; if (runs !== 5'b00010) begin bad++; $display("FAIL same_cycle_exit: runs=%b want 00010", runs); end
        pulse(c_P_VXV3, 32'h28000000);
        start = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        start = 1'b1;
        tick();
        pulse(c_P_VXV1, 32'h3F000000);
        repeat (63) tick();
        total++; if (runs !== 5'b01000 || error !== 1'b0) begin bad++; $display("FAIL wd_cycle64: runs=%b error=%b want 01000/0", runs, error); end
        tick();
        total++; if (error !== 1'b1 || runs !== 5'b0 || busy !== 1'b0) begin bad++; $display("FAIL wd_error: error=%b runs=%b busy=%b want 1/00000/0", error, runs, busy); end
        tick();
        total++; if (error !== 1'b1 || runs !== 5'b0) begin bad++; $display("FAIL wd_hold: error=%b runs=%b want 1/00000", error, runs); end
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        total++; if (runs !== 5'b10000 || error !== 1'b0) begin bad++; $display("FAIL wd_restart: runs=%b error=%b want 10000/0", runs, error); end
        abort = 1'b1; start = 1'b0;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        start = 1'b1;
        tick();
        pulse(c_P_VXV1, 32'h40000000);
        for (int k = 0; k < 3; k++) begin
            pulse(c_P_DIV1, 32'h0);
            pulse(c_P_MA12, 32'h0);
            pulse(c_P_VXV3, 32'h3F800000);
            pulse(c_P_DIV2, 32'h0);
            if (k < 2) pulse(c_P_MA3, 32'h0);
        end
        total++; if (runs !== 5'b00001 || iter_count !== 16'd2) begin bad++; $display("FAIL pre_abort: runs=%b iter=%0d want 00001/2", runs, iter_count); end
        abort = 1'b1; start = 1'b0;
        tick();
        abort = 1'b0;
        total++; if (runs !== 5'b0 || busy !== 1'b0 || iter_count !== 16'd2 || done !== 1'b0) begin bad++; $display("FAIL abort_updp: runs=%b busy=%b iter=%0d done=%b want 00000/0/2/0", runs, busy, iter_count, done); end
        tick();
        total++; if (runs !== 5'b0 || iter_count !== 16'd2) begin bad++; $display("FAIL abort_idle_hold: runs=%b iter=%0d want 00000/2", runs, iter_count); end
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        tick();
        pulse(c_P_VXV1, 32'h3F000000);
        pulse(c_P_DIV1, 32'h0);
        pulse(c_P_MA12, 32'h0);
        total++; if (vxv3_run !== 1'b1 || rs_old !== 32'h3F000000) begin bad++; $display("FAIL pre_reset_rsnew: vxv3_run=%b rs_old=%h want 1/3f000000", vxv3_run, rs_old); end
        #2 reset = 1'b0;
        #1;
        total++; if ({runs, div2_start, busy, done, converged, error} !== 10'b0 || {rs_old, rs_new, iter_count} !== 80'b0) begin bad++; $display("FAIL async_reset: flags=%b rs_old=%h rs_new=%h iter=%0d want all 0", {runs, div2_start, busy, done, converged, error}, rs_old, rs_new, iter_count); end
        tick();
        reset = 1'b1;
        tick();
        total++; if (runs !== 5'b10000) begin bad++; $display("FAIL post_reset_start: runs=%b want 10000", runs); end
        abort = 1'b1; start = 1'b0;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_converge();
        test_iter_limit();
        test_updxr_order();
        test_watchdog();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cg_iteration_sequencer.md
# cg_iteration_sequencer

Top-level sequencer for the conjugate-gradient ALU datapath. It drives the stage run/start controls in CG order and waits on each stage's finish flag. It holds the rs_old/rs_new scalars, applies the convergence tolerance and iteration limit, and guards every wait with a watchdog. It sits between the host/testbench command interface and the ALU stage instances, replacing the ad-hoc start/flag logic that currently lives inside the ALU top.

## Interface
Parameters:
- `element_width`, 32, width of scalar results (rs values)
- `tolerance`, 32'h283424DC, convergence threshold (IEEE-754 single bit pattern)
- `max_iter`, 16, maximum CG iterations before giving up (≥1)
- `iter_width`, 16, width of iteration counter
- `timeout`, 4096, cycles allowed per wait state before error (≥2)

Ports:
- `clk`  in  1  system clock, all logic on posedge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  level; begin a solve when sampled high in IDLE
- `abort`  in  1  synchronous; return to IDLE from any state
- `vxv1_finish`, `vxv3_finish`, `div1_finish`, `div2_finish`  in  1 each  stage done flags
- `mul_add1_finish`, `mul_add2_finish`, `mul_add3_finish`  in  1 each  update-stage done flags
- `vxv1_result`, `vxv3_result`  in  element_width  r·r results
- `vxv1_run`, `mxv_run`, `upd_xr_run`, `vxv3_run`, `upd_p_run`  out  1 each  level run enables (datapath reset = !run)
- `div2_start`  out  1  one-cycle pulse
- `rs_old`, `rs_new`  out  element_width  latched scalars (div2 operands)
- `iter_count`  out  iter_width  completed iterations
- `busy`, `done`, `converged`, `error`  out  1 each  status

## Operation
- States: IDLE, RSOLD, AP, UPD_XR, RSNEW, DIV2, UPD_P, DONE, ERROR.
- IDLE: all runs low. If `start`=1, go to RSOLD, clear iter_count, done, converged, error.
- RSOLD: vxv1_run=1. On vxv1_finish, latch rs_old←vxv1_result and go to AP.
- AP: mxv_run=1 (vXv2 and div1 chain off mXv1 in the datapath). On div1_finish, go to UPD_XR.
- UPD_XR: upd_xr_run=1. Sticky flags record mul_add1_finish and mul_add2_finish. Both may arrive in either order or in the same cycle. Leave once both are set; clear the flags on exit. Next state is RSNEW.
- RSNEW: vxv3_run=1. On vxv3_finish, latch rs_new←vxv3_result, then decide:
  - unsigned compare vxv3_result ≤ tolerance → DONE with converged=1;
  - else iter_count+1 = max_iter → iter_count++ and go to DONE with converged=0;
  - else → DIV2.
- DIV2: div2_start pulses high in the first cycle only. On div2_finish, go to UPD_P.
- UPD_P: upd_p_run=1. On mul_add3_finish: rs_old←rs_new, iter_count++, go to AP.
- DONE: done=1. Stay until `start`=0, then go to IDLE. done stays high in IDLE until the next start.
- ERROR: error=1, all runs low. Leave to IDLE on abort, or when `start`=0.
- Watchdog: counter clears on every state entry and counts in every wait state (RSOLD..UPD_P). Reaching `timeout` → ERROR.
- abort has priority over every transition. It goes to IDLE, drops all runs, clears the sticky flags, and keeps iter_count.
- Finish flags are ignored outside their own wait state.
- busy=1 in RSOLD..UPD_P.

## Timing
- Reset (async, low): state=IDLE. All outputs are 0, including rs_old, rs_new, iter_count and status.
- All outputs are registered and Moore-decoded. A run is high starting the first cycle in its state.
- A finish sampled high at an edge changes state at that edge. The old run drops in the next cycle and the new run rises in that same cycle, giving zero idle cycles.
- start→vxv1_run rise: 1 cycle.
- vxv3_finish→done: 1 cycle.
- A div2_finish in the same cycle as div2_start is accepted.
- Reset assertion mid-solve returns to IDLE immediately, without waiting for a clock edge.

## Structure
- Shared package `cg_pkg`: the state enum, element_width, and the default tolerance constant.
- One natural sub-module, `stage_watchdog`: a counter with clear, enable and timeout-hit output.
- The sequencer itself is a single FSM plus a datapath for the scalar registers and iteration counter.

## Test plan
- Converge in 1 iteration: vxv3_result=32'h28000000.
  → done=1, converged=1, iter_count=0.
  → rs_new=32'h28000000; DIV2 and UPD_P are never entered.
- Iteration limit: max_iter=4, vxv3_result always 32'h3F800000.
  → done=1, converged=0, iter_count=4.
  → div2_start pulses exactly 3 times; rs_old equals the prior rs_new after each UPD_P.
- UPD_XR ordering: drive mul_add2_finish 5 cycles before mul_add1_finish, then a run with both in the same cycle.
  → both runs exit UPD_XR exactly 1 cycle after the later/same-cycle finish.
- Watchdog: withhold div1_finish, timeout=64.
  → error=1 after 64 cycles in AP; mxv_run=0.
  → start=0 then returns the block to IDLE.
- Abort in UPD_P with iter_count=2 → IDLE next cycle, all runs 0, iter_count=2, busy=0.
- Async reset asserted mid-cycle during RSNEW → all outputs 0 before the next edge.
  → release reset, then start → vxv1_run high 1 cycle later.
